multiplier_controller: RTL and testbench

//  Sequencing FSM for the signed 8x8 add-shift multiplier around the 9-bit adder.
//  - Clears X:A and loads B; for each bit issues an add/sub cycle then an arithmetic right-shift cycle.
//  - Final iteration uses subtract (two's-complement multiplier).
//  - Sits between the top-level switch/button inputs and the X/A/B register datapath.

---
 rtl/multiplier_controller_pkg.sv | 5 +
 rtl/multiplier_controller_if.sv | 23 ++
 rtl/multiplier_controller_iter_counter.sv | 25 ++
 rtl/multiplier_controller.sv | 80 ++++++++
 tb/tb_multiplier_controller.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/multiplier_controller_pkg.sv
// Shared types and sizing for the add-shift multiplier controller.
package mult_ctrl_pkg;
   localparam int unsigned MULT_N_BITS = 8;
   typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, HOLD} mult_state_t;
endpackage

// File: rtl/multiplier_controller_if.sv
// Control/status bundle between the front panel, the controller and the X/A/B datapath.
interface multiplier_controller_if;
   logic Run;
   logic ClearA_LoadB;
   logic M;
   logic Clr_XA;
   logic Ld_B;
   logic Add_En;
   logic Fn;
   logic Shift_En;
   logic Busy;
   logic Done;

   modport master (
      output Run, ClearA_LoadB, M,
      input  Clr_XA, Ld_B, Add_En, Fn, Shift_En, Busy, Done
   );

   modport slave (
      input  Run, ClearA_LoadB, M,
      output Clr_XA, Ld_B, Add_En, Fn, Shift_En, Busy, Done
   );
endinterface

// File: rtl/multiplier_controller_iter_counter.sv
// Iteration index for the add/shift loop; flags the final (sign) iteration.
module mult_iter_counter #(
   parameter  int unsigned N_BITS = 8,
   localparam int unsigned W      = (N_BITS > 1) ? $clog2(N_BITS) : 1
) (
   input  logic Clk,
   input  logic Reset,
   input  logic clr,
   input  logic inc,
   output logic last
);
   logic [W-1:0] cnt;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + W'(1);
      end
   end

   assign last = (cnt == W'(N_BITS - 1));
endmodule

// File: rtl/multiplier_controller.sv
// Sequencing FSM for the signed add-shift multiplier: clear, then N add/shift pairs, then hold.
module multiplier_controller
   import mult_ctrl_pkg::*;
#(
   parameter int unsigned N_BITS = MULT_N_BITS
) (
   input logic                   Clk,
   input logic                   Reset,
   multiplier_controller_if.slave bus
);
   mult_state_t state;
   mult_state_t state_nxt;
   logic        last;
   logic        armed;

   mult_iter_counter #(.N_BITS(N_BITS)) u_cnt (
      .Clk   (Clk),
      .Reset (Reset),
      .clr   (state == CLR),
      .inc   ((state == SHIFT) && !last),
      .last  (last)
   );

   // armed stays low for the cycle in which reset is released so IDLE outputs remain quiet
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         armed <= 1'b0;
      end else begin
         state <= state_nxt;
         armed <= 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.Run) state_nxt = CLR;
         CLR:     state_nxt = ADD;
         ADD:     state_nxt = SHIFT;
         SHIFT:   state_nxt = last ? HOLD : ADD;
         HOLD:    if (!bus.Run) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.Clr_XA   = 1'b0;
      bus.Ld_B     = 1'b0;
      bus.Add_En   = 1'b0;
      bus.Fn       = 1'b0;
      bus.Shift_En = 1'b0;
      bus.Busy     = 1'b0;
      bus.Done     = 1'b0;
      case (state)
         IDLE: begin
            if (armed && !bus.Run) begin
               bus.Ld_B   = bus.ClearA_LoadB;
               bus.Clr_XA = bus.ClearA_LoadB;
            end
         end
         CLR: begin
            bus.Clr_XA = 1'b1;
            bus.Busy   = 1'b1;
         end
         ADD: begin
            // last iteration subtracts: the multiplier MSB carries negative weight
            bus.Add_En = bus.M;
            bus.Fn     = last;
            bus.Busy   = 1'b1;
         end
         SHIFT: begin
            bus.Shift_En = 1'b1;
            bus.Busy     = 1'b1;
         end
         HOLD:    bus.Done = 1'b1;
         default: ;
      endcase
   end
endmodule

// File: tb/tb_multiplier_controller.sv
// Self-checking bench: cycle timeline checks plus a behavioural X/A/B datapath for product checks.
module tb_multiplier_controller;
   import mult_ctrl_pkg::*;

   localparam int N = MULT_N_BITS;

   logic Clk = 1'b0;
   logic Reset;
   int   checks = 0;
   int   errors = 0;
   int   m_mode = 0;   // 0: M tied 0, 1: M tied 1, 2: M from datapath B[0]

   logic [7:0] s_sw, b_sw, A, B;
   logic       X;

   multiplier_controller_if bus ();

   multiplier_controller #(.N_BITS(N)) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   always #5 Clk = ~Clk;

   assign bus.M = (m_mode == 2) ? B[0] : (m_mode == 1);

   // X/A/B datapath with a 9-bit adder, driven only by the controller outputs
   always @(posedge Clk) begin
      if (bus.Ld_B) B <= b_sw;
      if (bus.Clr_XA) begin
         X <= 1'b0;
         A <= '0;
      end else if (bus.Add_En) begin
         {X, A} <= bus.Fn ? ({A[7], A} - {s_sw[7], s_sw}) : ({A[7], A} + {s_sw[7], s_sw});
      end else if (bus.Shift_En) begin
         A <= {X, A[7:1]};
         B <= {A[0], B[7:1]};
      end
   end

   function automatic logic [6:0] outs();
      return {bus.Clr_XA, bus.Ld_B, bus.Add_En, bus.Fn, bus.Shift_En, bus.Busy, bus.Done};
   endfunction

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // One full operation; every cycle compared against the documented timeline
   task automatic run_timeline(input int mode, input int hold, input bit noisy,
                               output int n_add, output int n_shift);
      logic [6:0] exp_v;
      logic       m_now;
      bit         is_add;
      n_add   = 0;
      n_shift = 0;
      m_mode  = mode;
      @(negedge Clk);
      bus.Run          = 1'b1;
      bus.ClearA_LoadB = noisy ? 1'($urandom) : 1'b0;
      #1;
      checks++;
      if (bus.Ld_B !== 1'b0) begin
         errors++;
         $display("FAIL run_priority Ld_B got %b want 0", bus.Ld_B);
      end
      for (int k = 1; k <= 2 * N + 1 + hold; k++) begin
         tick();
         m_now  = (mode == 2) ? B[0] : (mode == 1);
         is_add = (k >= 2) && (k <= 2 * N) && (k % 2 == 0);
         exp_v  = {1'(k == 1), 1'b0, 1'(is_add && m_now), 1'(k == 2 * N),
                   1'((k >= 3) && (k <= 2 * N + 1) && (k % 2 == 1)),
                   1'(k <= 2 * N + 1), 1'(k >= 2 * N + 2)};
         checks++;
         if (outs() !== exp_v) begin
            errors++;
            $display("FAIL timeline cycle %0d outs(clr,ldb,add,fn,sh,busy,done) got %b want %b",
                     k, outs(), exp_v);
         end
         if (bus.Add_En === 1'b1) n_add++;
         if (bus.Shift_En === 1'b1) n_shift++;
         @(negedge Clk);
         if (noisy && k < 2 * N) begin
            bus.Run          = 1'($urandom);
            bus.ClearA_LoadB = 1'($urandom);
         end else begin
            bus.Run          = 1'b1;
            bus.ClearA_LoadB = 1'b0;
         end
      end
      bus.Run = 1'b0;
      tick();
      checks++;
      if (outs() !== 7'b0) begin
         errors++;
         $display("FAIL release_to_idle outs got %b want 0000000", outs());
      end
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      bus.Run = 1'b0;
      bus.ClearA_LoadB = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (outs() !== 7'b0) begin
            errors++;
            $display("FAIL reset_outs got %b want 0000000", outs());
         end
         tick();
      end
      @(negedge Clk);
      bus.ClearA_LoadB = 1'b0;
      Reset = 1'b0;
      tick();
      checks++;
      if (outs() !== 7'b0) begin
         errors++;
         $display("FAIL post_reset_idle got %b want 0000000", outs());
      end
      // start an operation and reset it during ADD at iteration 3 (cycle 8)
      m_mode = 1;
      @(negedge Clk);
      bus.Run = 1'b1;
      for (int k = 1; k <= 8; k++) tick();
      checks++;
      if ({bus.Add_En, bus.Fn, bus.Busy} !== 3'b101) begin
         errors++;
         $display("FAIL mid_add_cnt3 add,fn,busy got %b want 101", {bus.Add_En, bus.Fn, bus.Busy});
      end
      #2 Reset = 1'b1;
      #1;
      checks++;
      if (outs() !== 7'b0) begin
         errors++;
         $display("FAIL mid_op_reset got %b want 0000000", outs());
      end
      @(negedge Clk);
      bus.Run = 1'b0;
      Reset = 1'b0;
      tick();
   endtask

   task automatic test_idle_load();
      b_sw = 8'($urandom);
      @(negedge Clk);
      bus.ClearA_LoadB = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (outs() !== 7'b1100000) begin
            errors++;
            $display("FAIL idle_load cycle %0d got %b want 1100000", i, outs());
         end
      end
      checks++;
      if (B !== b_sw || A !== 8'h00 || X !== 1'b0) begin
         errors++;
         $display("FAIL idle_load_regs X,A,B got %b,%h,%h want 0,00,%h", X, A, B, b_sw);
      end
      @(negedge Clk);
      bus.ClearA_LoadB = 1'b0;
      #1;
      checks++;
      if (outs() !== 7'b0) begin
         errors++;
         $display("FAIL idle_quiet got %b want 0000000", outs());
      end
   endtask

   task automatic test_m_ones();
      int na, ns;
      run_timeline(1, 1, 1'b0, na, ns);
      checks++;
      if (na != N || ns != N) begin
         errors++;
         $display("FAIL m_ones_pulses add,shift got %0d,%0d want %0d,%0d", na, ns, N, N);
      end
   endtask

   task automatic test_m_zeros();
      int na, ns;
      run_timeline(0, 1, 1'b0, na, ns);
      checks++;
      if (na != 0 || ns != N) begin
         errors++;
         $display("FAIL m_zeros_pulses add,shift got %0d,%0d want 0,%0d", na, ns, N);
      end
   endtask

   task automatic test_hold_run();
      int na, ns;
      run_timeline(1, 30 - (2 * N + 1), 1'b0, na, ns);
      checks++;
      if (na != N || ns != N) begin
         errors++;
         $display("FAIL hold_single_op add,shift got %0d,%0d want %0d,%0d", na, ns, N, N);
      end
      run_timeline(0, 2, 1'b0, na, ns);
   endtask

   task automatic check_product(input logic [7:0] s, input logic [7:0] b, input bit noisy);
      int               na, ns;
      logic signed [15:0] prod;
      s_sw = s;
      b_sw = b;
      @(negedge Clk);
      bus.ClearA_LoadB = 1'b1;
      tick();
      @(negedge Clk);
      bus.ClearA_LoadB = 1'b0;
      run_timeline(2, 1, noisy, na, ns);
      prod = 16'($signed(s) * $signed(b));
      checks++;
      if ({A, B} !== prod || X !== prod[15]) begin
         errors++;
         $display("FAIL product s=%h b=%h X,AB got %b,%h want %b,%h", s, b, X, {A, B}, prod[15], prod);
      end
   endtask

   task automatic test_datapath();
      check_product(8'hF9, 8'h03, 1'b0);
      check_product(8'h80, 8'h80, 1'b0);
      check_product(8'h7F, 8'h80, 1'b0);
      for (int i = 0; i < 10; i++) check_product(8'($urandom), 8'($urandom), 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      bus.Run = 1'b0;
      bus.ClearA_LoadB = 1'b0;
      s_sw = '0;
      b_sw = '0;
      test_reset();
      test_idle_load();
      test_m_ones();
      test_m_zeros();
      test_hold_run();
      test_datapath();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
